// File: rtl/sram_burst_master_pkg.sv
// Shared widths, FSM encoding and read-buffer sizing for the SRAM burst master.
package sram_burst_master_pkg;

  localparam int unsigned DEF_A_WIDTH   = 8;
  localparam int unsigned DEF_D_WIDTH   = 8;
  localparam int unsigned DEF_LEN_WIDTH = 8;
  localparam int unsigned RD_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StRead  = 2'd2,
    StDrain = 2'd3
  } state_e;

  // A new read may be issued only while buffered plus outstanding words leave a free slot.
  function automatic logic credit_ok(input int unsigned occupancy);
    return occupancy < RD_FIFO_DEPTH;
  endfunction

endpackage

// File: rtl/sram_burst_master_rd_fifo.sv
// Small synchronous FIFO buffering SRAM read data ahead of the consumer.
module sram_burst_master_rd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign o_count   = r_count;
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_rdata   = r_mem[r_rd_ptr];
  // A pop frees the slot on the same edge, so a full FIFO can still take a push.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sram_burst_master.sv
// Burst initiator for a single-port synchronous SRAM: streams write beats in and
// credit-limited read beats out through a small buffer with consumer backpressure.
module sram_burst_master
  import sram_burst_master_pkg::*;
#(
  parameter int unsigned A_WIDTH   = DEF_A_WIDTH,
  parameter int unsigned D_WIDTH   = DEF_D_WIDTH,
  parameter int unsigned LEN_WIDTH = DEF_LEN_WIDTH
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Cmd_Valid,
  output logic                 Cmd_Ready,
  input  logic                 Cmd_RW,
  input  logic [A_WIDTH-1:0]   Cmd_Addr,
  input  logic [LEN_WIDTH-1:0] Cmd_Len,
  input  logic [D_WIDTH-1:0]   Wr_Data,
  input  logic                 Wr_Valid,
  output logic                 Wr_Ready,
  output logic [D_WIDTH-1:0]   Rd_Data,
  output logic                 Rd_Valid,
  input  logic                 Rd_Ready,
  output logic                 Busy,
  output logic                 Mem_En,
  output logic                 Mem_RW,
  output logic [A_WIDTH-1:0]   Mem_Addr,
  output logic [D_WIDTH-1:0]   Mem_Wdata,
  input  logic [D_WIDTH-1:0]   Mem_Rdata
);

  localparam int unsigned CNT_W = $clog2(RD_FIFO_DEPTH + 1);

  state_e               r_state;
  state_e               w_state_next;
  logic [A_WIDTH-1:0]   r_cur;
  logic [LEN_WIDTH-1:0] r_remain;
  logic                 r_mem_en;
  logic                 r_mem_rw;
  logic [A_WIDTH-1:0]   r_mem_addr;
  logic [D_WIDTH-1:0]   r_mem_wdata;
  logic                 r_rd_pend;

  logic                 w_cmd_hs;
  logic                 w_wr_hs;
  logic                 w_rd_issue;
  logic                 w_last;
  logic                 w_rd_inflight;
  logic                 w_credit;
  logic                 w_drained;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic                 w_fifo_pop;
  logic [CNT_W-1:0]     w_fifo_count;

  assign w_cmd_hs      = Cmd_Valid && Cmd_Ready;
  assign w_wr_hs       = Wr_Valid && Wr_Ready;
  assign w_last        = (r_remain == '0);
  // Read currently on the SRAM pins; its data returns next cycle.
  assign w_rd_inflight = r_mem_en && !r_mem_rw;
  assign w_credit      = !w_fifo_full &&
                         credit_ok(32'(w_fifo_count) + 32'(r_rd_pend) + 32'(w_rd_inflight));
  assign w_drained     = w_fifo_empty && !r_rd_pend && !w_rd_inflight;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_cmd_hs) w_state_next = Cmd_RW ? StWrite : StRead;
      StWrite: if (w_wr_hs && w_last) w_state_next = StIdle;
      StRead:  if (w_rd_issue && w_last) w_state_next = StDrain;
      StDrain: if (w_drained) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    Cmd_Ready  = 1'b0;
    Wr_Ready   = 1'b0;
    Busy       = 1'b1;
    w_rd_issue = 1'b0;
    unique case (r_state)
      StIdle: begin
        Cmd_Ready = 1'b1;
        Busy      = 1'b0;
      end
      StWrite: Wr_Ready   = 1'b1;
      StRead:  w_rd_issue = w_credit;
      StDrain: ;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_cur       <= '0;
      r_remain    <= '0;
      r_mem_en    <= 1'b0;
      r_mem_rw    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rd_pend   <= 1'b0;
    end else begin
      r_mem_en  <= w_wr_hs || w_rd_issue;
      r_rd_pend <= w_rd_inflight;
      if (w_cmd_hs) begin
        r_cur    <= Cmd_Addr;
        r_remain <= Cmd_Len;
      end else if (w_wr_hs || w_rd_issue) begin
        r_cur    <= r_cur + 1'b1;
        r_remain <= r_remain - 1'b1;
      end
      if (w_wr_hs) begin
        r_mem_rw    <= 1'b1;
        r_mem_addr  <= r_cur;
        r_mem_wdata <= Wr_Data;
      end else if (w_rd_issue) begin
        r_mem_rw   <= 1'b0;
        r_mem_addr <= r_cur;
      end
    end
  end

  assign Mem_En    = r_mem_en;
  assign Mem_RW    = r_mem_rw;
  assign Mem_Addr  = r_mem_addr;
  assign Mem_Wdata = r_mem_wdata;

  assign Rd_Valid   = !w_fifo_empty;
  assign w_fifo_pop = Rd_Ready && Rd_Valid;

  // Mem_Rdata is captured only in the cycle right after a read was on the pins.
  sram_burst_master_rd_fifo #(
    .WIDTH(D_WIDTH),
    .DEPTH(RD_FIFO_DEPTH)
  ) u_rd_fifo (
    .i_clk  (Clk),
    .i_rst  (Rst),
    .i_push (r_rd_pend),
    .i_wdata(Mem_Rdata),
    .i_pop  (w_fifo_pop),
    .o_rdata(Rd_Data),
    .o_full (w_fifo_full),
    .o_empty(w_fifo_empty),
    .o_count(w_fifo_count)
  );

endmodule
